// File: rtl/tipi_pkg.sv
// tipi_pkg: shared width rules and r_sel decode helpers for the TIPI link register bank.
// Exports sel_w/ch_w/cnt_w width functions and sel_is_t/sel_ch select-field decoders.
package tipi_pkg;

    function automatic int sel_w(input int nch);
        return $clog2(2 * nch);
    endfunction

    function automatic int ch_w(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

    // Counter must hold 0..WIDTH+1 (saturation value marks an overflowed frame).
    function automatic int cnt_w(input int width);
        return $clog2(width + 2);
    endfunction

    function automatic logic sel_is_t(input logic [31:0] sel, input int sw);
        return sel[sw-1];
    endfunction

    // With a single channel the select field has no channel bits at all.
    function automatic int unsigned sel_ch(input logic [31:0] sel, input int sw);
        return (sw > 1) ? (sel & ((32'd1 << (sw - 1)) - 32'd1)) : 32'd0;
    endfunction

endpackage

// File: rtl/tipi_link_regs_if.sv
// tipi_link_regs_if: RPi serial link and TI-side strobe/flag bundle of the TIPI register bank.
// master drives r_clk/r_le/r_dout/r_sel and the ti_wr/ti_rd strobes; slave (the bank)
// drives r_din, ti_rd_data, t_pend, r_new, irq and ovf.
interface tipi_link_regs_if import tipi_pkg::*; #(
    parameter int WIDTH = 8,
    parameter int NCH   = 2
) ();
    localparam int SEL_W = sel_w(NCH);
    localparam int CH_W  = ch_w(NCH);

    logic             r_clk;
    logic             r_le;
    logic             r_dout;
    logic [SEL_W-1:0] r_sel;
    logic             r_din;
    logic             ti_wr;
    logic [CH_W-1:0]  ti_wr_ch;
    logic [WIDTH-1:0] ti_wr_data;
    logic             ti_rd;
    logic [CH_W-1:0]  ti_rd_ch;
    logic [WIDTH-1:0] ti_rd_data;
    logic [NCH-1:0]   t_pend;
    logic [NCH-1:0]   r_new;
    logic             irq;
    logic             ovf;

    modport master (
        output r_clk, r_le, r_dout, r_sel, ti_wr, ti_wr_ch, ti_wr_data, ti_rd, ti_rd_ch,
        input  r_din, ti_rd_data, t_pend, r_new, irq, ovf
    );

    modport slave (
        input  r_clk, r_le, r_dout, r_sel, ti_wr, ti_wr_ch, ti_wr_data, ti_rd, ti_rd_ch,
        output r_din, ti_rd_data, t_pend, r_new, irq, ovf
    );
endinterface

// File: rtl/tipi_sync.sv
// tipi_sync: STAGES-deep synchroniser for the async RPi link plus rising-edge detect of its clock.
// Ports: clk, rst; edge_i (async shift clock), data_i (other async inputs);
// data_o (synced data), rise_o (one-clk pulse on synced edge_i rising).
module tipi_sync #(
    parameter int W      = 1,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         edge_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] data_o,
    output logic         rise_o
);
    // Clock and data travel through identical chains so they stay aligned.
    logic [W:0] stg_q [STAGES];
    logic       prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stg_q  <= '{default: '0};
            prev_q <= 1'b0;
        end else begin
            stg_q[0] <= {edge_i, data_i};
            for (int i = 1; i < STAGES; i++) stg_q[i] <= stg_q[i-1];
            prev_q <= stg_q[STAGES-1][W];
        end
    end

    assign data_o = stg_q[STAGES-1][W-1:0];
    assign rise_o = stg_q[STAGES-1][W] & ~prev_q;
endmodule

// File: rtl/tipi_link_regs.sv
// tipi_link_regs: NCH pairs of T (TI->RPi) and R (RPi->TI) registers behind an oversampled serial link.
// Ports: clk, rst (sync, active-high); bus (slave modport) carrying the RPi link
// (r_clk, r_le, r_dout, r_sel in; r_din out) and the TI side (ti_wr/ti_rd strobes,
// ti_rd_data, t_pend, r_new, irq, ovf).
module tipi_link_regs import tipi_pkg::*; #(
    parameter int WIDTH       = 8,
    parameter int NCH         = 2,
    parameter int SYNC_STAGES = 2
) (
    input logic             clk,
    input logic             rst,
    tipi_link_regs_if.slave bus
);
    localparam int SEL_W = sel_w(NCH);
    localparam int CH_W  = ch_w(NCH);
    localparam int CNT_W = cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(WIDTH + 1);

    logic [SEL_W-1:0] sel_s;
    logic             le_s, dout_s, ev;

    tipi_sync #(.W(SEL_W + 2), .STAGES(SYNC_STAGES)) u_sync (
        .clk    (clk),
        .rst    (rst),
        .edge_i (bus.r_clk),
        .data_i ({bus.r_sel, bus.r_dout, bus.r_le}),
        .data_o ({sel_s, dout_s, le_s}),
        .rise_o (ev)
    );

    logic [WIDTH-1:0] t_q [NCH], t_d [NCH], r_q [NCH], r_d [NCH];
    logic [WIDTH-1:0] shf_q, shf_d, acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SEL_W-1:0] sel_last_q, sel_last_d;
    logic [NCH-1:0]   t_pend_q, t_pend_d, r_new_q, r_new_d;
    logic             par_q, par_d, din_q, din_d, ovf_q, ovf_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            t_q        <= '{default: '0};
            r_q        <= '{default: '0};
            shf_q      <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            sel_last_q <= '0;
            t_pend_q   <= '0;
            r_new_q    <= '0;
            par_q      <= 1'b0;
            din_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            t_q        <= t_d;
            r_q        <= r_d;
            shf_q      <= shf_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            sel_last_q <= sel_last_d;
            t_pend_q   <= t_pend_d;
            r_new_q    <= r_new_d;
            par_q      <= par_d;
            din_q      <= din_d;
            ovf_q      <= ovf_d;
        end
    end

    logic             is_t, ch_ok, wr_ok, rd_ok, sel_chg, b_par;
    logic [CH_W-1:0]  ch;
    logic [WIDTH-1:0] b_shf, b_acc;
    logic [CNT_W-1:0] b_cnt, cnt_inc;

    assign is_t  = sel_is_t(32'(sel_s), SEL_W);
    assign ch    = CH_W'(sel_ch(32'(sel_s), SEL_W));
    assign ch_ok = sel_ch(32'(sel_s), SEL_W) < NCH;
    assign wr_ok = 32'(bus.ti_wr_ch) < NCH;
    assign rd_ok = 32'(bus.ti_rd_ch) < NCH;

    // A new selection discards the in-flight frame before the event acts on it.
    assign sel_chg = sel_s != sel_last_q;
    assign b_shf   = sel_chg ? '0 : shf_q;
    assign b_acc   = sel_chg ? '0 : acc_q;
    assign b_par   = sel_chg ? 1'b0 : par_q;
    assign b_cnt   = sel_chg ? '0 : cnt_q;
    assign cnt_inc = (b_cnt == CNT_SAT) ? b_cnt : b_cnt + CNT_W'(1);

    always_comb begin
        t_d        = t_q;
        r_d        = r_q;
        shf_d      = shf_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        sel_last_d = sel_last_q;
        t_pend_d   = t_pend_q;
        r_new_d    = r_new_q;
        par_d      = par_q;
        din_d      = din_q;
        ovf_d      = ovf_q;
        // Read clear comes first so a same-cycle commit leaves r_new set.
        if (bus.ti_rd && rd_ok) r_new_d[bus.ti_rd_ch] = 1'b0;
        if (ev) begin
            sel_last_d = sel_s;
            if (ch_ok) begin
                shf_d = b_shf;
                acc_d = b_acc;
                par_d = b_par;
                cnt_d = b_cnt;
                if (is_t && le_s) begin
                    shf_d        = t_q[ch];
                    cnt_d        = '0;
                    din_d        = t_q[ch][WIDTH-1];
                    t_pend_d[ch] = 1'b0;
                end else if (is_t) begin
                    shf_d = b_shf << 1;
                    din_d = b_shf[WIDTH-2];
                    cnt_d = cnt_inc;
                    ovf_d = ovf_q | (b_cnt == CNT_FULL);
                end else if (!le_s) begin
                    acc_d = {b_acc[WIDTH-2:0], dout_s};
                    par_d = b_par ^ dout_s;
                    din_d = b_par ^ dout_s;
                    cnt_d = cnt_inc;
                    ovf_d = ovf_q | (b_cnt == CNT_FULL);
                end else begin
                    r_d[ch]     = b_acc;
                    r_new_d[ch] = 1'b1;
                    acc_d       = '0;
                    par_d       = 1'b0;
                    cnt_d       = '0;
                    din_d       = 1'b0;
                end
            end
        end
        // Write comes last: a same-cycle RPi load saw the old T and t_pend ends set.
        if (bus.ti_wr && wr_ok) begin
            t_d[bus.ti_wr_ch]      = bus.ti_wr_data;
            t_pend_d[bus.ti_wr_ch] = 1'b1;
        end
    end

    assign bus.r_din      = din_q & ch_ok;
    assign bus.ti_rd_data = rd_ok ? r_q[bus.ti_rd_ch] : '0;
    assign bus.t_pend     = t_pend_q;
    assign bus.r_new      = r_new_q;
    assign bus.irq        = |r_new_q;
    assign bus.ovf        = ovf_q;
endmodule

// File: tb/tb_tipi_link_regs.sv
// tb_tipi_link_regs: directed bench with a frame-level model checked every cycle.
module tb_tipi_link_regs;
    localparam int W  = 8;
    localparam int N  = 2;
    localparam int SS = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tipi_link_regs_if #(.WIDTH(W), .NCH(N)) bus ();

    tipi_link_regs #(.WIDTH(W), .NCH(N), .SYNC_STAGES(SS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int ntests = 0;
    int nfail  = 0;
    bit chk_en = 1'b0;

    // Model: register contents, flags and the current frame as seen by the RPi.
    logic [W-1:0] m_t [N];
    logic [W-1:0] m_r [N];
    logic [N-1:0] m_tp, m_rn;
    logic [W-1:0] m_shf, m_acc;
    logic         m_par, m_din, m_ovf;
    logic [1:0]   m_last;
    int           m_n;
    logic         last_din;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_t[i] = '0;
            m_r[i] = '0;
        end
        m_tp = '0; m_rn = '0; m_shf = '0; m_acc = '0;
        m_par = 0; m_din = 0; m_ovf = 0; m_last = '0; m_n = 0;
    endtask

    task automatic model_event(input logic [1:0] sel, input logic le, input logic d);
        int c;
        c = int'(sel[0]);
        if (sel != m_last) begin
            m_shf = '0; m_acc = '0; m_par = 0; m_n = 0;
        end
        m_last = sel;
        if (sel[1] && le) begin
            m_shf = m_t[c]; m_n = 0; m_din = m_shf[W-1]; m_tp[c] = 0;
        end else if (sel[1]) begin
            if (m_n >= W) m_ovf = 1;
            m_n++;
            m_shf = m_shf << 1;
            m_din = m_shf[W-1];
        end else if (!le) begin
            if (m_n >= W) m_ovf = 1;
            m_n++;
            m_acc = {m_acc[W-2:0], d};
            m_par = m_par ^ d;
            m_din = m_par;
        end else begin
            m_r[c] = m_acc; m_rn[c] = 1;
            m_acc = '0; m_par = 0; m_n = 0; m_din = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("r_din", bus.r_din, m_din);
            check("t_pend", bus.t_pend, m_tp);
            check("r_new", bus.r_new, m_rn);
            check("irq", bus.irq, |m_rn);
            check("ovf", bus.ovf, m_ovf);
            check("ti_rd_data", bus.ti_rd_data, m_r[bus.ti_rd_ch]);
        end
    end

    // One r_clk pulse; optional TI write/read strobe lands on the same clk as the action.
    task automatic rpi_edge(input logic [1:0] sel, input logic le, input logic d,
                            input bit cw = 0, input int cw_ch = 0, input logic [W-1:0] cw_dat = '0,
                            input bit cr = 0, input int cr_ch = 0);
        bus.r_sel = sel; bus.r_le = le; bus.r_dout = d;
        repeat (SS + 1) tick();
        bus.r_clk = 1'b1;
        repeat (SS) tick();
        if (cw) begin
            bus.ti_wr = 1'b1; bus.ti_wr_ch = 1'(cw_ch); bus.ti_wr_data = cw_dat;
        end
        if (cr) begin
            bus.ti_rd = 1'b1; bus.ti_rd_ch = 1'(cr_ch);
        end
        tick();
        bus.ti_wr = 1'b0; bus.ti_rd = 1'b0;
        if (cr) m_rn[cr_ch] = 0;
        model_event(sel, le, d);
        if (cw) begin
            m_t[cw_ch] = cw_dat; m_tp[cw_ch] = 1;
        end
        @(negedge clk) last_din = bus.r_din;
        repeat (SS) tick();
        bus.r_clk = 1'b0;
        repeat (SS + 2) tick();
    endtask

    task automatic send_r(input int c, input logic [W-1:0] v, input int nbits);
        for (int i = nbits - 1; i >= 0; i--) rpi_edge({1'b0, 1'(c)}, 1'b0, v[i]);
    endtask

    task automatic ti_write(input int c, input logic [W-1:0] v);
        bus.ti_wr = 1'b1; bus.ti_wr_ch = 1'(c); bus.ti_wr_data = v;
        tick();
        bus.ti_wr = 1'b0;
        m_t[c] = v; m_tp[c] = 1;
    endtask

    task automatic ti_read(input int c);
        bus.ti_rd = 1'b1; bus.ti_rd_ch = 1'(c);
        tick();
        bus.ti_rd = 1'b0;
        m_rn[c] = 0;
    endtask

    logic [W-1:0] seq;

    initial begin
        bus.r_clk = 0; bus.r_le = 0; bus.r_dout = 0; bus.r_sel = '0;
        bus.ti_wr = 0; bus.ti_wr_ch = '0; bus.ti_wr_data = '0;
        bus.ti_rd = 0; bus.ti_rd_ch = '0;
        model_reset();
        repeat (3) tick();
        rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        check("reset_ovf", bus.ovf, 0);
        check("reset_irq", bus.irq, 0);
        check("reset_tpend", bus.t_pend, 0);

        ti_write(1, 8'hA5);
        @(negedge clk) check("tpend_after_wr", bus.t_pend, 2'b10);
        rpi_edge(2'b11, 1'b1, 1'b0);
        seq[7] = last_din;
        for (int i = 6; i >= 0; i--) begin
            rpi_edge(2'b11, 1'b0, 1'b0);
            seq[i] = last_din;
        end
        check("t1_serial", seq, 8'hA5);
        check("tpend_after_load", bus.t_pend, 0);

        send_r(0, 8'h3C, 8);
        check("r0_parity_echo", last_din, 0);
        rpi_edge(2'b00, 1'b1, 1'b0);
        bus.ti_rd_ch = 1'b0;
        @(negedge clk);
        check("r0_data", bus.ti_rd_data, 8'h3C);
        check("r0_new", bus.r_new, 2'b01);
        check("r0_irq", bus.irq, 1);
        ti_read(0);
        @(negedge clk);
        check("rd_clears_new", bus.r_new, 0);
        check("rd_clears_irq", bus.irq, 0);

        send_r(0, 8'hFF, 8);
        check("no_ovf_at_width", bus.ovf, 0);
        send_r(0, 8'h01, 1);
        check("ovf_ninth", bus.ovf, 1);
        rpi_edge(2'b00, 1'b1, 1'b0);
        send_r(0, 8'h11, 8);
        rpi_edge(2'b00, 1'b1, 1'b0);
        check("ovf_sticky", bus.ovf, 1);
        check("r0_after_ovf", bus.ti_rd_data, 8'h11);
        ti_read(0);

        send_r(1, 8'h0B, 4);
        send_r(0, 8'hFF, 8);
        check("selchg_parity", last_din, 0);
        rpi_edge(2'b00, 1'b1, 1'b0);
        @(negedge clk) check("selchg_r0", bus.ti_rd_data, 8'hFF);
        bus.ti_rd_ch = 1'b1;
        @(negedge clk) check("selchg_r1", bus.ti_rd_data, 8'h00);

        ti_read(0);
        send_r(0, 8'h5A, 8);
        rpi_edge(2'b00, 1'b1, 1'b0, 0, 0, '0, 1, 0);
        check("commit_vs_read", bus.r_new[0], 1);

        ti_write(0, 8'hC3);
        rpi_edge(2'b10, 1'b1, 1'b0, 1, 0, 8'h3C);
        check("coload_old_msb", last_din, 1);
        check("coload_tpend", bus.t_pend[0], 1);
        rpi_edge(2'b10, 1'b0, 1'b0);
        check("coload_old_bit6", last_din, 1);
        rpi_edge(2'b10, 1'b1, 1'b0);
        check("reload_new_msb", last_din, 0);

        send_r(1, 8'h07, 3);
        rst = 1'b1;
        tick();
        model_reset();
        rst = 1'b0;
        send_r(1, 8'h81, 8);
        rpi_edge(2'b01, 1'b1, 1'b0);
        bus.ti_rd_ch = 1'b1;
        @(negedge clk);
        check("rst_r1", bus.ti_rd_data, 8'h81);
        check("rst_ovf", bus.ovf, 0);
        check("rst_new", bus.r_new, 2'b10);
        check("rst_tpend", bus.t_pend, 0);
        bus.ti_rd_ch = 1'b0;
        @(negedge clk) check("rst_r0", bus.ti_rd_data, 8'h00);

        tick();
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
